// File: rtl/prime_gen_if.sv
// ============================================================================
//  Module      : prime_gen_if
//  Description : Handshake and status bundle for the prime_gen sequential
//                prime generator. It carries the start request, the
//                valid/ready prime output, and the busy, done and count
//                status signals.
//                  start        -> generator  single-cycle scan request
//                  prime_ready  -> generator  consumer accepts prime_out
//                  prime_out    <- generator  current prime (WIDTH bits)
//                  prime_valid  <- generator  prime_out awaits acceptance
//                  busy         <- generator  scan in progress
//                  done         <- generator  scan complete
//                  prime_count  <- generator  primes accepted (CNT_W bits)
//                master = generator side, slave = consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface prime_gen_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] prime_out;
    logic             prime_valid;
    logic             prime_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] prime_count;

    modport master (
        input  start,
        input  prime_ready,
        output prime_out,
        output prime_valid,
        output busy,
        output done,
        output prime_count
    );

    modport slave (
        output start,
        output prime_ready,
        input  prime_out,
        input  prime_valid,
        input  busy,
        input  done,
        input  prime_count
    );
endinterface

`default_nettype wire

// File: rtl/prime_gen.sv
// ============================================================================
//  Module      : prime_gen
//  Description : Emits every prime that fits in WIDTH bits, in ascending
//                order, over a valid/ready handshake. Each candidate from 2
//                up to 2^WIDTH-1 is tested by trial division, one divisor
//                per clock. A candidate is prime once div*div exceeds it
//                without a divisor having been found.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - prime_gen_if master modport (start, prime_ready in;
//                         prime_out, prime_valid, busy, done, prime_count out)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prime_gen #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    prime_gen_if.master  bus
);

    localparam int               c_SQ_W     = 2 * WIDTH;
    localparam logic [WIDTH-1:0] c_CAND_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_TWO      = WIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TEST = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state,       w_state_nxt;
    logic [WIDTH-1:0] r_cand,        w_cand_nxt;
    logic [WIDTH-1:0] r_div,         w_div_nxt;
    logic [WIDTH-1:0] r_prime_out,   w_prime_out_nxt;
    logic             r_prime_valid, w_prime_valid_nxt;
    logic             r_busy,        w_busy_nxt;
    logic             r_done,        w_done_nxt;
    logic [CNT_W-1:0] r_prime_count, w_prime_count_nxt;

    logic [c_SQ_W-1:0] w_div_sq;
    logic              w_sq_gt;
    logic [WIDTH-1:0]  w_div_safe;
    logic              w_is_factor;
    logic              w_advance;

    // Square at double width so the prime test cannot overflow.
    assign w_div_sq = c_SQ_W'(r_div) * c_SQ_W'(r_div);
    assign w_sq_gt  = w_div_sq > c_SQ_W'(r_cand);

    // div is 0 only outside TEST; keep the remainder well defined there.
    assign w_div_safe  = (r_div == '0) ? WIDTH'(1) : r_div;
    assign w_is_factor = (r_cand % w_div_safe) == '0;

    always_comb begin
        w_state_nxt       = r_state;
        w_cand_nxt        = r_cand;
        w_div_nxt         = r_div;
        w_prime_out_nxt   = r_prime_out;
        w_prime_valid_nxt = r_prime_valid;
        w_busy_nxt        = r_busy;
        w_done_nxt        = r_done;
        w_prime_count_nxt = r_prime_count;
        w_advance         = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_cand_nxt        = c_TWO;
                    w_div_nxt         = c_TWO;
                    w_prime_count_nxt = '0;
                    w_done_nxt        = 1'b0;
                    w_busy_nxt        = 1'b1;
                    w_state_nxt       = S_TEST;
                end
            end
            S_TEST: begin
                if (w_sq_gt) begin
                    w_prime_out_nxt   = r_cand;
                    w_prime_valid_nxt = 1'b1;
                    w_state_nxt       = S_EMIT;
                end else if (w_is_factor) begin
                    w_advance = 1'b1;
                end else begin
                    w_div_nxt = r_div + WIDTH'(1);
                end
            end
            S_EMIT: begin
                // prime_valid is always high here, so ready alone completes
                // the handshake.
                if (bus.prime_ready) begin
                    w_prime_valid_nxt = 1'b0;
                    w_prime_count_nxt = r_prime_count + CNT_W'(1);
                    w_advance         = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Shared step to the next candidate; stops at the top value so the
        // candidate never wraps back to 0.
        if (w_advance) begin
            if (r_cand == c_CAND_MAX) begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_DONE;
            end else begin
                w_cand_nxt  = r_cand + WIDTH'(1);
                w_div_nxt   = c_TWO;
                w_state_nxt = S_TEST;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cand        <= '0;
            r_div         <= '0;
            r_prime_out   <= '0;
            r_prime_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_prime_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cand        <= w_cand_nxt;
            r_div         <= w_div_nxt;
            r_prime_out   <= w_prime_out_nxt;
            r_prime_valid <= w_prime_valid_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_prime_count <= w_prime_count_nxt;
        end
    end

    assign bus.prime_out   = r_prime_out;
    assign bus.prime_valid = r_prime_valid;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.prime_count = r_prime_count;

endmodule

`default_nettype wire

// File: tb/tb_prime_gen.sv
// ============================================================================
//  Module      : tb_prime_gen
//  Description : Directed testbench for prime_gen. A WIDTH=4 instance covers
//                reset, full scan, backpressure, ignored start, restart and
//                asynchronous reset. A WIDTH=5 instance runs with prime_ready
//                toggling and its output is cross-checked against a prime
//                detector for every value 0..31.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prime_gen;

    logic clk;
    logic rst_n;

    int checks = 0;
    int fails  = 0;

    prime_gen_if #(.WIDTH(4), .CNT_W(8)) bus4 ();
    prime_gen_if #(.WIDTH(5), .CNT_W(8)) bus5 ();

    prime_gen #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.master)
    );

    prime_gen #(.WIDTH(5), .CNT_W(8)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus4.prime_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", bus4.prime_valid); end
        checks++; if (bus4.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus4.busy); end
        checks++; if (bus4.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus4.done); end
        checks++; if (bus4.prime_count !== 8'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", bus4.prime_count); end
        checks++; if (bus4.prime_out !== 4'd0) begin fails++; $display("FAIL reset_out got=%0d exp=0", bus4.prime_out); end
        repeat (20) @(negedge clk);
        checks++; if (bus4.busy !== 1'b0 || bus4.prime_valid !== 1'b0) begin fails++; $display("FAIL idle_hold busy=%b valid=%b exp 0,0", bus4.busy, bus4.prime_valid); end
    endtask

    task automatic test_full_scan();
        int q[$];
        int exp4[6] = '{2, 3, 5, 7, 11, 13};
        int cyc = 0;
        bus4.prime_ready = 1'b1;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        checks++; if (bus4.busy !== 1'b1 || bus4.prime_valid !== 1'b0) begin fails++; $display("FAIL scan_first_edge busy=%b valid=%b exp 1,0", bus4.busy, bus4.prime_valid); end
        @(negedge clk);
        checks++; if (bus4.prime_valid !== 1'b1 || bus4.prime_out !== 4'd2) begin fails++; $display("FAIL scan_first_prime valid=%b out=%0d exp 1,2", bus4.prime_valid, bus4.prime_out); end
        while (!bus4.done && cyc < 500) begin
            if (bus4.prime_valid && bus4.prime_ready) q.push_back(int'(bus4.prime_out));
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc >= 500) begin fails++; $display("FAIL scan_timeout cycles=%0d limit=500", cyc); end
        checks++; if (q.size() !== 6) begin fails++; $display("FAIL scan_len got=%0d exp=6", q.size()); end
        for (int i = 0; i < 6 && i < q.size(); i++) begin
            checks++; if (q[i] !== exp4[i]) begin fails++; $display("FAIL scan_seq[%0d] got=%0d exp=%0d", i, q[i], exp4[i]); end
        end
        checks++; if (bus4.done !== 1'b1 || bus4.busy !== 1'b0 || bus4.prime_valid !== 1'b0) begin fails++; $display("FAIL scan_end done=%b busy=%b valid=%b exp 1,0,0", bus4.done, bus4.busy, bus4.prime_valid); end
        checks++; if (bus4.prime_count !== 8'd6) begin fails++; $display("FAIL scan_count got=%0d exp=6", bus4.prime_count); end
    endtask

    task automatic test_backpressure();
        int q[$];
        int exp4[6] = '{2, 3, 5, 7, 11, 13};
        int cyc = 0;
        bit held = 1'b0;
        bus4.prime_ready = 1'b1;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        while (!bus4.done && cyc < 500) begin
            if (bus4.prime_valid && bus4.prime_out == 4'd5 && !held) begin
                bus4.prime_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    checks++; if (bus4.prime_valid !== 1'b1 || bus4.prime_out !== 4'd5) begin fails++; $display("FAIL bp_hold[%0d] valid=%b out=%0d exp 1,5", i, bus4.prime_valid, bus4.prime_out); end
                end
                bus4.prime_ready = 1'b1;
                held = 1'b1;
            end
            if (bus4.prime_valid && bus4.prime_ready) q.push_back(int'(bus4.prime_out));
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc >= 500 || !held) begin fails++; $display("FAIL bp_run cycles=%0d held=%b exp <500,1", cyc, held); end
        checks++; if (q.size() !== 6) begin fails++; $display("FAIL bp_len got=%0d exp=6", q.size()); end
        for (int i = 0; i < 6 && i < q.size(); i++) begin
            checks++; if (q[i] !== exp4[i]) begin fails++; $display("FAIL bp_seq[%0d] got=%0d exp=%0d", i, q[i], exp4[i]); end
        end
        checks++; if (bus4.prime_count !== 8'd6) begin fails++; $display("FAIL bp_count got=%0d exp=6", bus4.prime_count); end
    endtask

    task automatic test_start_ignored_and_restart();
        int q[$];
        int exp4[6] = '{2, 3, 5, 7, 11, 13};
        int cyc = 0;
        bit hit_test = 1'b0;
        bit hit_emit = 1'b0;
        bus4.prime_ready = 1'b1;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        while (!bus4.done && cyc < 500) begin
            bus4.start = 1'b0;
            if (q.size() == 2 && bus4.busy && !bus4.prime_valid && !hit_test) begin
                bus4.start = 1'b1;
                hit_test = 1'b1;
            end else if (bus4.prime_valid && bus4.prime_out == 4'd7 && !hit_emit) begin
                bus4.start = 1'b1;
                hit_emit = 1'b1;
            end
            if (bus4.prime_valid && bus4.prime_ready) q.push_back(int'(bus4.prime_out));
            @(negedge clk);
            cyc++;
        end
        bus4.start = 1'b0;
        checks++; if (!hit_test || !hit_emit || cyc >= 500) begin fails++; $display("FAIL ign_run test=%b emit=%b cycles=%0d", hit_test, hit_emit, cyc); end
        checks++; if (q.size() !== 6) begin fails++; $display("FAIL ign_len got=%0d exp=6", q.size()); end
        for (int i = 0; i < 6 && i < q.size(); i++) begin
            checks++; if (q[i] !== exp4[i]) begin fails++; $display("FAIL ign_seq[%0d] got=%0d exp=%0d", i, q[i], exp4[i]); end
        end
        repeat (3) @(negedge clk);
        checks++; if (bus4.done !== 1'b1 || bus4.prime_count !== 8'd6) begin fails++; $display("FAIL done_hold done=%b count=%0d exp 1,6", bus4.done, bus4.prime_count); end
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        checks++; if (bus4.done !== 1'b0 || bus4.prime_count !== 8'd0 || bus4.busy !== 1'b1) begin fails++; $display("FAIL restart done=%b count=%0d busy=%b exp 0,0,1", bus4.done, bus4.prime_count, bus4.busy); end
        @(negedge clk);
        checks++; if (bus4.prime_valid !== 1'b1 || bus4.prime_out !== 4'd2) begin fails++; $display("FAIL restart_first valid=%b out=%0d exp 1,2", bus4.prime_valid, bus4.prime_out); end
    endtask

    task automatic test_async_reset();
        int cyc = 0;
        // Continue the scan restarted above until 7 is offered, then stall.
        bus4.prime_ready = 1'b1;
        while (!(bus4.prime_valid && bus4.prime_out == 4'd7) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        bus4.prime_ready = 1'b0;
        checks++; if (cyc >= 500) begin fails++; $display("FAIL arst_reach_7 cycles=%0d limit=500", cyc); end
        repeat (2) @(negedge clk);
        checks++; if (bus4.prime_count !== 8'd3 || bus4.prime_out !== 4'd7) begin fails++; $display("FAIL arst_pre count=%0d out=%0d exp 3,7", bus4.prime_count, bus4.prime_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus4.prime_valid !== 1'b0 || bus4.prime_out !== 4'd0) begin fails++; $display("FAIL arst_out valid=%b out=%0d exp 0,0", bus4.prime_valid, bus4.prime_out); end
        checks++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.prime_count !== 8'd0) begin fails++; $display("FAIL arst_status busy=%b done=%b count=%0d exp 0,0,0", bus4.busy, bus4.done, bus4.prime_count); end
        @(negedge clk);
        rst_n = 1'b1;
        bus4.prime_ready = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (bus4.prime_valid !== 1'b0 || bus4.busy !== 1'b0) begin fails++; $display("FAIL arst_after valid=%b busy=%b exp 0,0", bus4.prime_valid, bus4.busy); end
    endtask

    task automatic test_width5();
        int q[$];
        int exp5[11] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31};
        bit seen[32];
        int cyc = 0;
        for (int i = 0; i < 32; i++) seen[i] = 1'b0;
        bus5.prime_ready = 1'b0;
        bus5.start = 1'b1;
        @(negedge clk);
        bus5.start = 1'b0;
        while (!bus5.done && cyc < 2000) begin
            bus5.prime_ready = ~bus5.prime_ready;
            if (bus5.prime_valid && bus5.prime_ready) q.push_back(int'(bus5.prime_out));
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc >= 2000) begin fails++; $display("FAIL w5_timeout cycles=%0d limit=2000", cyc); end
        checks++; if (q.size() !== 11) begin fails++; $display("FAIL w5_len got=%0d exp=11", q.size()); end
        for (int i = 0; i < 11 && i < q.size(); i++) begin
            checks++; if (q[i] !== exp5[i]) begin fails++; $display("FAIL w5_seq[%0d] got=%0d exp=%0d", i, q[i], exp5[i]); end
        end
        checks++; if (bus5.prime_count !== 8'd11 || bus5.done !== 1'b1) begin fails++; $display("FAIL w5_end count=%0d done=%b exp 11,1", bus5.prime_count, bus5.done); end
        foreach (q[i]) if (q[i] >= 0 && q[i] < 32) seen[q[i]] = 1'b1;
        for (int n = 0; n < 32; n++) begin
            checks++; if (seen[n] !== is_prime(n)) begin fails++; $display("FAIL w5_detector n=%0d emitted=%b F=%b", n, seen[n], is_prime(n)); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus4.start = 1'b0;
        bus4.prime_ready = 1'b0;
        bus5.start = 1'b0;
        bus5.prime_ready = 1'b0;
        test_reset();
        test_full_scan();
        test_backpressure();
        test_start_ignored_and_restart();
        test_async_reset();
        test_width5();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
